// File: rtl/ibex_mem_arbiter.sv
// Instruction/data arbiter onto one pipelined memory port: round-robin selection,
// request locking until grant, and an in-order FIFO that routes responses back.
module ibex_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic [2:0]  outstanding_o,
  output logic        protocol_err_o
);

  typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} src_e;

  localparam logic [2:0] MaxCnt  = 3'(MaxOutstanding);
  localparam logic [1:0] LastIdx = 2'(MaxOutstanding - 1);

  src_e       r_fifo [4];
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;
  logic [2:0] r_count;
  logic       r_lock;
  src_e       r_lock_src;
  src_e       r_last_grant;
  logic       r_protocol_err;

  src_e       w_sel;
  src_e       w_head;
  logic       w_sel_req;
  logic       w_full;
  logic       w_push;
  logic       w_pop;
  logic       w_stray;

  // A locked source keeps the port until granted so attributes never change mid-request.
  always_comb begin
    w_sel = SRC_INSTR;
    if (r_lock) begin
      w_sel = r_lock_src;
    end else if (instr_req_i && data_req_i) begin
      w_sel = (r_last_grant == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    end else if (data_req_i) begin
      w_sel = SRC_DATA;
    end
  end

  assign w_full    = (r_count == MaxCnt);
  assign w_sel_req = (w_sel == SRC_DATA) ? data_req_i : instr_req_i;
  assign w_push    = mem_req_o && mem_gnt_i;
  assign w_pop     = mem_rvalid_i && (r_count != '0) && !rst_i;
  assign w_stray   = mem_rvalid_i && (r_count == '0);
  assign w_head    = r_fifo[r_rptr];

  assign mem_req_o   = w_sel_req && !w_full && !rst_i;
  assign mem_we_o    = (w_sel == SRC_DATA) ? data_we_i    : 1'b0;
  assign mem_be_o    = (w_sel == SRC_DATA) ? data_be_i    : 4'b1111;
  assign mem_addr_o  = (w_sel == SRC_DATA) ? data_addr_i  : instr_addr_i;
  assign mem_wdata_o = (w_sel == SRC_DATA) ? data_wdata_i : '0;

  assign instr_gnt_o    = w_push && (w_sel == SRC_INSTR);
  assign data_gnt_o     = w_push && (w_sel == SRC_DATA);
  assign instr_rvalid_o = w_pop && (w_head == SRC_INSTR);
  assign data_rvalid_o  = w_pop && (w_head == SRC_DATA);
  assign instr_err_o    = instr_rvalid_o && mem_err_i;
  assign data_err_o     = data_rvalid_o && mem_err_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  assign outstanding_o  = r_count;
  assign protocol_err_o = r_protocol_err;

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_fifo[r_wptr] <= w_sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_lock         <= 1'b0;
      r_lock_src     <= SRC_INSTR;
      r_last_grant   <= SRC_INSTR;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr       <= (r_wptr == LastIdx) ? '0 : r_wptr + 2'd1;
        r_last_grant <= w_sel;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == LastIdx) ? '0 : r_rptr + 2'd1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 3'd1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 3'd1;
      end
      // mem_req_o is already low when full, so the lock can never capture a stalled slot.
      if (w_push) begin
        r_lock <= 1'b0;
      end else if (mem_req_o) begin
        r_lock     <= 1'b1;
        r_lock_src <= w_sel;
      end
      if (w_stray) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

endmodule
